axi_lite_dp_bram: RTL and testbench

AXI4-Lite slave front-end on a parametrised dual-port block RAM. The second, native port is for the systolic-array partial-reconfiguration region. The PS side loads and reads operand/result buffers over AXI4-Lite while the accelerator streams the same memory through a simple enable/write-enable port. This block supersedes the fixed 4-register, 32-bit BRAM IP. It adds configurable width and depth, byte strobes, out-of-range error responses, independent AW/W acceptance and a shared-memory collision policy.

---
 rtl/axi_lite_dp_bram.sv | 166 ++++++++++++++++
 tb/tb_axi_lite_dp_bram.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_dp_bram.sv
// AXI4-Lite slave front-end on a dual-port block RAM; the native port serves the
// accelerator region and wins any per-byte write collision with an AXI commit.
module axi_lite_dp_bram #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 12,
  parameter int DEPTH      = 256
) (
  input  logic                       ACLK,
  input  logic                       ARESETN,
  input  logic [ADDR_WIDTH-1:0]      S_AXI_AWADDR,
  input  logic [2:0]                 S_AXI_AWPROT,
  input  logic                       S_AXI_AWVALID,
  output logic                       S_AXI_AWREADY,
  input  logic [DATA_WIDTH-1:0]      S_AXI_WDATA,
  input  logic [DATA_WIDTH/8-1:0]    S_AXI_WSTRB,
  input  logic                       S_AXI_WVALID,
  output logic                       S_AXI_WREADY,
  output logic [1:0]                 S_AXI_BRESP,
  output logic                       S_AXI_BVALID,
  input  logic                       S_AXI_BREADY,
  input  logic [ADDR_WIDTH-1:0]      S_AXI_ARADDR,
  input  logic [2:0]                 S_AXI_ARPROT,
  input  logic                       S_AXI_ARVALID,
  output logic                       S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]      S_AXI_RDATA,
  output logic [1:0]                 S_AXI_RRESP,
  output logic                       S_AXI_RVALID,
  input  logic                       S_AXI_RREADY,
  input  logic                       bram_en,
  input  logic [DATA_WIDTH/8-1:0]    bram_we,
  input  logic [$clog2(DEPTH)-1:0]   bram_addr,
  input  logic [DATA_WIDTH-1:0]      bram_wdata,
  output logic [DATA_WIDTH-1:0]      bram_rdata
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int LSB    = $clog2(STRB_W);
  localparam int IDX_W  = ADDR_WIDTH - LSB;
  localparam int RAM_AW = $clog2(DEPTH);
  localparam logic [IDX_W:0] DEPTH_LIM = (IDX_W + 1)'(DEPTH);

  typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} wr_state_t;
  typedef enum logic {R_IDLE, R_DATA} rd_state_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  wr_state_t             wr_state;
  rd_state_t             rd_state;
  logic                  ready_en;
  logic                  aw_held;
  logic                  w_held;
  logic [IDX_W-1:0]      wr_idx;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [STRB_W-1:0]     wr_strb;
  logic [IDX_W-1:0]      rd_idx;
  logic                  aw_hs;
  logic                  w_hs;
  logic                  ar_hs;
  logic                  wr_oor;
  logic                  rd_oor;
  logic                  axi_commit;
  logic                  unused_ok;

  // ready_en keeps every ready low during reset and until the first edge after it
  assign S_AXI_AWREADY = ready_en && !aw_held && !S_AXI_BVALID;
  assign S_AXI_WREADY  = ready_en && !w_held && !S_AXI_BVALID;
  assign S_AXI_ARREADY = ready_en && (rd_state == R_IDLE);

  assign aw_hs      = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs       = S_AXI_WVALID && S_AXI_WREADY;
  assign ar_hs      = S_AXI_ARVALID && S_AXI_ARREADY;
  assign rd_idx     = S_AXI_ARADDR[ADDR_WIDTH-1:LSB];
  assign wr_oor     = {1'b0, wr_idx} >= DEPTH_LIM;
  assign rd_oor     = {1'b0, rd_idx} >= DEPTH_LIM;
  assign axi_commit = (wr_state == W_COMMIT) && !wr_oor;
  assign unused_ok  = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT,
                        S_AXI_AWADDR[LSB-1:0], S_AXI_ARADDR[LSB-1:0]};

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      wr_state     <= W_IDLE;
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      wr_idx       <= '0;
      wr_data      <= '0;
      wr_strb      <= '0;
      S_AXI_BVALID <= 1'b0;
      S_AXI_BRESP  <= 2'b00;
    end else begin
      case (wr_state)
        W_IDLE: begin
          if (aw_hs) begin
            aw_held <= 1'b1;
            wr_idx  <= S_AXI_AWADDR[ADDR_WIDTH-1:LSB];
          end
          if (w_hs) begin
            w_held  <= 1'b1;
            wr_data <= S_AXI_WDATA;
            wr_strb <= S_AXI_WSTRB;
          end
          if ((aw_held || aw_hs) && (w_held || w_hs))
            wr_state <= W_COMMIT;
        end
        W_COMMIT: begin
          S_AXI_BVALID <= 1'b1;
          S_AXI_BRESP  <= wr_oor ? 2'b10 : 2'b00;
          wr_state     <= W_RESP;
        end
        W_RESP: begin
          if (S_AXI_BREADY) begin
            S_AXI_BVALID <= 1'b0;
            S_AXI_BRESP  <= 2'b00;
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
            wr_state     <= W_IDLE;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

  // Native bytes are written last so they override the AXI commit on the same word
  always_ff @(posedge ACLK) begin
    if (axi_commit) begin
      for (int b = 0; b < STRB_W; b++)
        if (wr_strb[b]) mem[wr_idx[RAM_AW-1:0]][b*8 +: 8] <= wr_data[b*8 +: 8];
    end
    if (bram_en) begin
      for (int b = 0; b < STRB_W; b++)
        if (bram_we[b]) mem[bram_addr][b*8 +: 8] <= bram_wdata[b*8 +: 8];
    end
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      ready_en     <= 1'b0;
      rd_state     <= R_IDLE;
      S_AXI_RVALID <= 1'b0;
      S_AXI_RRESP  <= 2'b00;
      S_AXI_RDATA  <= '0;
      bram_rdata   <= '0;
    end else begin
      ready_en <= 1'b1;
      if (bram_en) bram_rdata <= mem[bram_addr];
      case (rd_state)
        R_IDLE: begin
          if (ar_hs) begin
            S_AXI_RVALID <= 1'b1;
            S_AXI_RRESP  <= rd_oor ? 2'b10 : 2'b00;
            S_AXI_RDATA  <= rd_oor ? '0 : mem[rd_idx[RAM_AW-1:0]];
            rd_state     <= R_DATA;
          end
        end
        R_DATA: begin
          if (S_AXI_RREADY) begin
            S_AXI_RVALID <= 1'b0;
            rd_state     <= R_IDLE;
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_dp_bram.sv
// Randomized self-checking bench for axi_lite_dp_bram against a word-array model
// of the memory with byte strobes, out-of-range responses and native-port priority.
module tb_axi_lite_dp_bram;

  localparam int DEPTH = 256;

  logic        ACLK = 1'b0;
  logic        ARESETN = 1'b0;
  logic [11:0] S_AXI_AWADDR = '0;
  logic [2:0]  S_AXI_AWPROT = '0;
  logic        S_AXI_AWVALID = 1'b0;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA = '0;
  logic [3:0]  S_AXI_WSTRB = '0;
  logic        S_AXI_WVALID = 1'b0;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY = 1'b0;
  logic [11:0] S_AXI_ARADDR = '0;
  logic [2:0]  S_AXI_ARPROT = '0;
  logic        S_AXI_ARVALID = 1'b0;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY = 1'b0;
  logic        bram_en = 1'b0;
  logic [3:0]  bram_we = '0;
  logic [7:0]  bram_addr = '0;
  logic [31:0] bram_wdata = '0;
  logic [31:0] bram_rdata;

  logic [31:0] model [DEPTH];
  int assertCount = 0;
  int failCount = 0;

  axi_lite_dp_bram #(.DATA_WIDTH(32), .ADDR_WIDTH(12), .DEPTH(DEPTH)) dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
    .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
    .bram_wdata(bram_wdata), .bram_rdata(bram_rdata)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #2ms;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic mergeModel(input int idx, input logic [3:0] en, input logic [31:0] data);
    for (int b = 0; b < 4; b++)
      if (en[b]) model[idx][b*8 +: 8] = data[b*8 +: 8];
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_awready"}, S_AXI_AWREADY, 0);
    checkOutput({tag, "_wready"}, S_AXI_WREADY, 0);
    checkOutput({tag, "_arready"}, S_AXI_ARREADY, 0);
    checkOutput({tag, "_bvalid"}, S_AXI_BVALID, 0);
    checkOutput({tag, "_bresp"}, S_AXI_BRESP, 0);
    checkOutput({tag, "_rvalid"}, S_AXI_RVALID, 0);
    checkOutput({tag, "_rresp"}, S_AXI_RRESP, 0);
    checkOutput({tag, "_rdata"}, S_AXI_RDATA, 0);
    checkOutput({tag, "_bram_rdata"}, bram_rdata, 0);
  endtask

  task automatic nativeWrite(input int idx, input logic [3:0] we, input logic [31:0] data, input bit checkOld);
    logic [31:0] oldWord;
    oldWord = model[idx];
    bram_en = 1'b1; bram_we = we; bram_addr = 8'(idx); bram_wdata = data;
    tick();
    bram_en = 1'b0; bram_we = '0;
    if (checkOld) checkOutput("native_read_first", bram_rdata, oldWord);
    mergeModel(idx, we, data);
  endtask

  task automatic nativeRead(input int idx);
    bram_en = 1'b1; bram_we = '0; bram_addr = 8'(idx);
    tick();
    bram_en = 1'b0;
    checkOutput("native_rdata", bram_rdata, model[idx]);
    bram_addr = bram_addr + 8'd1;
    tick();
    checkOutput("native_rdata_hold", bram_rdata, model[idx]);
  endtask

  // Drives AW and W after independent delays and checks the B channel timing
  task automatic applyStimulus(input logic [11:0] addr, input logic [31:0] data, input logic [3:0] strb,
                               input int awDelay, input int wDelay, input int bHold);
    bit awDone = 0, wDone = 0, awHs, wHs;
    int cyc = 0;
    int idx;
    logic [1:0] expResp;
    idx = int'(addr[11:2]);
    S_AXI_AWADDR = addr; S_AXI_WDATA = data; S_AXI_WSTRB = strb;
    while (!(awDone && wDone) && cyc < 40) begin
      if (cyc == awDelay) S_AXI_AWVALID = 1'b1;
      if (cyc == wDelay) S_AXI_WVALID = 1'b1;
      awHs = S_AXI_AWVALID && S_AXI_AWREADY;
      wHs = S_AXI_WVALID && S_AXI_WREADY;
      tick();
      if (awHs) begin S_AXI_AWVALID = 1'b0; awDone = 1; end
      if (wHs) begin S_AXI_WVALID = 1'b0; wDone = 1; end
      cyc++;
    end
    if (!(awDone && wDone)) begin
      checkOutput("write_handshake_timeout", 0, 1);
      S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
      return;
    end
    checkOutput("bvalid_early", S_AXI_BVALID, 0);
    tick();
    expResp = (idx >= DEPTH) ? 2'b10 : 2'b00;
    checkOutput("bvalid_latency", S_AXI_BVALID, 1);
    checkOutput("bresp", S_AXI_BRESP, expResp);
    if (idx < DEPTH) mergeModel(idx, strb, data);
    for (int i = 0; i < bHold; i++) begin
      tick();
      checkOutput("bvalid_hold", S_AXI_BVALID, 1);
      checkOutput("bresp_hold", S_AXI_BRESP, expResp);
      checkOutput("awready_during_b", S_AXI_AWREADY, 0);
    end
    S_AXI_BREADY = 1'b1;
    tick();
    S_AXI_BREADY = 1'b0;
    checkOutput("bvalid_clear", S_AXI_BVALID, 0);
    checkOutput("awready_after_b", S_AXI_AWREADY, 1);
  endtask

  task automatic axiRead(input logic [11:0] addr, input int rHold);
    int cyc = 0;
    int idx;
    logic [31:0] expData;
    logic [1:0] expResp;
    idx = int'(addr[11:2]);
    S_AXI_ARADDR = addr; S_AXI_ARVALID = 1'b1;
    while (!S_AXI_ARREADY && cyc < 20) begin tick(); cyc++; end
    if (!S_AXI_ARREADY) begin
      checkOutput("read_handshake_timeout", 0, 1);
      S_AXI_ARVALID = 1'b0;
      return;
    end
    expData = (idx >= DEPTH) ? 32'h0 : model[idx];
    expResp = (idx >= DEPTH) ? 2'b10 : 2'b00;
    tick();
    S_AXI_ARVALID = 1'b0;
    checkOutput("rvalid_latency", S_AXI_RVALID, 1);
    checkOutput("rdata", S_AXI_RDATA, expData);
    checkOutput("rresp", S_AXI_RRESP, expResp);
    for (int i = 0; i < rHold; i++) begin
      tick();
      checkOutput("rdata_hold", S_AXI_RDATA, expData);
      checkOutput("rvalid_hold", S_AXI_RVALID, 1);
    end
    S_AXI_RREADY = 1'b1;
    tick();
    S_AXI_RREADY = 1'b0;
    checkOutput("rvalid_clear", S_AXI_RVALID, 0);
  endtask

  initial begin
    logic [31:0] oldWord;
    logic [31:0] rnd;
    int idx;
    int op;
    $display("[TB] starting axi_lite_dp_bram test");

    repeat (3) tick();
    checkAllZero("reset");
    #2 ARESETN = 1'b1;
    checkOutput("awready_before_first_edge", S_AXI_AWREADY, 0);
    tick();
    checkOutput("awready_after_reset", S_AXI_AWREADY, 1);
    checkOutput("wready_after_reset", S_AXI_WREADY, 1);
    checkOutput("arready_after_reset", S_AXI_ARREADY, 1);

    for (int i = 0; i < 32; i++) nativeWrite(i, 4'hF, $urandom, 1'b0);

    for (int i = 0; i < 4; i++) applyStimulus(12'(i * 4), 32'(i + 1), 4'hF, 0, 0, 0);
    for (int i = 0; i < 4; i++) axiRead(12'(i * 4), 0);
    checkOutput("word3_value", model[3], 32'h4);

    applyStimulus(12'h010, 32'hAABBCCDD, 4'hF, 0, 0, 0);
    applyStimulus(12'h010, 32'h11223344, 4'b0101, 0, 0, 0);
    axiRead(12'h010, 1);
    checkOutput("strobe_model", model[4], 32'hAA22CC44);

    applyStimulus(12'h020, 32'hCAFEF00D, 4'hF, 3, 0, 4);
    applyStimulus(12'h024, 32'h0BADBEEF, 4'hF, 0, 5, 0);
    axiRead(12'h020, 0);
    axiRead(12'h024, 2);

    applyStimulus(12'h400, 32'hDEADBEEF, 4'hF, 0, 0, 1);
    axiRead(12'h400, 0);
    axiRead(12'h000, 0);

    // Collision: AXI commit and native write land on word 5 in the same cycle
    nativeWrite(5, 4'hF, 32'h12345678, 1'b1);
    S_AXI_AWADDR = 12'h014; S_AXI_WDATA = 32'hFFFFFFFF; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1;
    checkOutput("collision_awready", S_AXI_AWREADY, 1);
    tick();
    S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
    bram_en = 1'b1; bram_addr = 8'd5; bram_we = 4'h3; bram_wdata = 32'h0;
    tick();
    bram_en = 1'b0; bram_we = '0;
    checkOutput("collision_bvalid", S_AXI_BVALID, 1);
    checkOutput("collision_native_old", bram_rdata, 32'h12345678);
    model[5] = 32'hFFFF0000;
    S_AXI_BREADY = 1'b1; tick(); S_AXI_BREADY = 1'b0;
    axiRead(12'h014, 0);
    nativeRead(5);

    // AXI read of a word the native port overwrites in the same cycle
    oldWord = model[6];
    rnd = $urandom;
    S_AXI_ARADDR = 12'h018; S_AXI_ARVALID = 1'b1;
    bram_en = 1'b1; bram_addr = 8'd6; bram_we = 4'hF; bram_wdata = rnd;
    tick();
    S_AXI_ARVALID = 1'b0; bram_en = 1'b0; bram_we = '0;
    checkOutput("axi_read_first_rvalid", S_AXI_RVALID, 1);
    checkOutput("axi_read_first_rdata", S_AXI_RDATA, oldWord);
    model[6] = rnd;
    S_AXI_RREADY = 1'b1; tick(); S_AXI_RREADY = 1'b0;
    nativeRead(6);

    // Reset between AW and W handshakes discards the write
    axiRead(12'h004, 0);
    nativeRead(1);
    S_AXI_AWADDR = 12'h01C; S_AXI_AWVALID = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0;
    #2 ARESETN = 1'b0;
    #1 checkAllZero("midreset");
    S_AXI_WDATA = 32'h55555555; S_AXI_WSTRB = 4'hF;
    tick();
    ARESETN = 1'b1;
    tick();
    tick();
    checkOutput("midreset_no_bvalid", S_AXI_BVALID, 0);
    checkOutput("midreset_awready", S_AXI_AWREADY, 1);
    axiRead(12'h01C, 0);
    applyStimulus(12'h01C, 32'h600DF00D, 4'hF, 0, 0, 0);
    axiRead(12'h01C, 0);

    for (int n = 0; n < 60; n++) begin
      op = int'($urandom_range(0, 3));
      idx = ($urandom_range(0, 7) == 0) ? int'($urandom_range(256, 1023)) : int'($urandom_range(0, 31));
      case (op)
        0: applyStimulus(12'(idx * 4 + int'($urandom_range(0, 3))), $urandom, 4'($urandom_range(0, 15)),
                         int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), int'($urandom_range(0, 2)));
        1: axiRead(12'(idx * 4 + int'($urandom_range(0, 3))), int'($urandom_range(0, 2)));
        2: nativeWrite(idx % 32, 4'($urandom_range(0, 15)), $urandom, 1'b1);
        default: nativeRead(idx % 32);
      endcase
    end

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
